// File: rtl/fir_inverse.sv
// fir_inverse: recovers 8-bit samples from the 3-tap filter output
// y[n] = 3*x[n] + 2*x[n-1] + x[n-2] using exact division by 3 with a
// 19-step restoring divider. Flags inexact or saturated results.
module fir_inverse (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [17:0] result_i,
  input  logic        result_en_i,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        drop_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StDiv, StDone} state_e;

  state_e      state_q;
  logic [17:0] y_q;
  logic [7:0]  x1_q, x2_q;
  logic [18:0] mag_q;
  logic        neg_q;
  logic [1:0]  rem_q;
  logic [18:0] quo_q;
  logic [4:0]  cnt_q;
  logic [7:0]  data_q;
  logic        valid_q, err_q, busy_q, drop_q;

  logic [19:0] num;
  logic [18:0] num_mag;
  logic [2:0]  trial;
  logic        ge;
  logic [1:0]  rem_next;
  logic [19:0] quo_signed;
  logic        sat_hi, sat_lo;
  logic [7:0]  data_sat;

  // Numerator, one divider step and signed saturation of the quotient
  always_comb begin
    num = {{2{y_q[17]}}, y_q}
        - {{11{x1_q[7]}}, x1_q, 1'b0}
        - {{12{x2_q[7]}}, x2_q};
    // |num| never exceeds 131456, so 19 bits hold the two's-complement negation
    num_mag  = num[19] ? (~num[18:0] + 19'd1) : num[18:0];
    trial    = {rem_q, mag_q[18]};
    ge       = (trial >= 3'd3);
    // For trial in 3..5, trial-3 equals trial[1:0]+1 modulo 4
    rem_next = ge ? (trial[1:0] + 2'd1) : trial[1:0];
    quo_signed = neg_q ? (20'd0 - {1'b0, quo_q}) : {1'b0, quo_q};
    sat_hi   = ($signed(quo_signed) > 20'sd127);
    sat_lo   = ($signed(quo_signed) < -20'sd128);
    if (sat_hi) begin
      data_sat = 8'h7f;
    end else if (sat_lo) begin
      data_sat = 8'h80;
    end else begin
      data_sat = quo_signed[7:0];
    end
  end

  // Decode FSM with registered outputs and sample history
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      y_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      drop_q  <= result_en_i && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (result_en_i) begin
            y_q     <= result_i;
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          neg_q   <= num[19];
          mag_q   <= num_mag;
          rem_q   <= '0;
          quo_q   <= '0;
          cnt_q   <= 5'd18;
          state_q <= StDiv;
        end
        StDiv: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[17:0], ge};
          mag_q <= {mag_q[17:0], 1'b0};
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          data_q  <= data_sat;
          err_q   <= (rem_q != 2'd0) | sat_hi | sat_lo;
          valid_q <= 1'b1;
          x2_q    <= x1_q;
          x1_q    <= data_sat;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;
  assign drop_o       = drop_q;

endmodule

// File: tb/tb_fir_inverse.sv
// Testbench for fir_inverse: directed scenarios plus random stimulus, checked
// by a scoreboard fed from an arithmetic reference model of the inverse filter.
module tb_fir_inverse;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] result = '0;
  logic        result_en = 1'b0;
  logic [7:0]  data;
  logic        data_valid, err, busy, drop;

  fir_inverse dut (
    .clk_i        (clk),
    .rst_n        (rst_n),
    .result_i     (result),
    .result_en_i  (result_en),
    .data_o       (data),
    .data_valid_o (data_valid),
    .err_o        (err),
    .busy_o       (busy),
    .drop_o       (drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int d;
    int e;
    int t;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_x1 = 0;
  int   m_x2 = 0;
  int   drops_seen = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: exact inverse with truncating division and clipping
  task automatic model_push(input int y, input int t);
    int num, q, r, s;
    exp_t ex;
    num = y - 2 * m_x1 - m_x2;
    q = num / 3;
    r = num % 3;
    s = q;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    ex.d = s;
    ex.e = ((r != 0) || (s != q)) ? 1 : 0;
    ex.t = t;
    sb.push_back(ex);
    m_x2 = m_x1;
    m_x1 = s;
  endtask

  // Monitor: compare every completion against the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t ex;
          ex = sb.pop_front();
          check("data", int'($signed(data)), ex.d);
          check("err", int'(err), ex.e);
          check("latency", cyc - ex.t, 21);
        end
      end
      if (drop) drops_seen++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input int y, input bit accepted);
    @(negedge clk);
    #1;
    result    = 18'(y);
    result_en = 1'b1;
    if (accepted) model_push(y, cyc + 1);
    @(negedge clk);
    #1;
    result_en = 1'b0;
    if (accepted) check("busy_after_accept", int'(busy), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    m_x1 = 0;
    m_x2 = 0;
    repeat (2) @(negedge clk);
    check("rst_outputs", int'({data, data_valid, err, busy, drop}), 0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int d0, xs, y;
    repeat (3) @(negedge clk);
    check("reset_state", int'({data, data_valid, err, busy, drop}), 0);
    #2;
    rst_n = 1'b1;

    // Exact sequence
    strobe(30, 1);  idle(23);
    strobe(5, 1);   idle(23);
    strobe(300, 1); drain();

    // Inexact then exact with history
    do_reset();
    strobe(31, 1); idle(23);
    strobe(20, 1); drain();

    // Saturation
    do_reset();
    strobe(600, 1);  drain();
    do_reset();
    strobe(-384, 1); drain();
    do_reset();
    strobe(-387, 1); drain();

    // Overrun: second strobe is dropped
    do_reset();
    d0 = drops_seen;
    strobe(30, 1); idle(3);
    strobe(99, 0); drain();
    check("drop_count", drops_seen - d0, 1);
    strobe(20, 1); drain();

    // Reset mid-operation
    do_reset();
    strobe(30, 1);
    idle(8);
    do_reset();
    idle(25);
    check("post_abort_outputs", int'({data, data_valid, err, busy, drop}), 0);
    strobe(15, 1); drain();

    // Boundary with saturated history
    do_reset();
    strobe(381, 1);     idle(23);
    strobe(635, 1);     idle(23);
    strobe(131071, 1);  idle(23);
    strobe(-131072, 1); drain();

    // Random: mostly near-invertible values, some full-range
    for (int i = 0; i < 40; i++) begin
      xs = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 3) == 0) begin
        y = int'($urandom_range(0, 262143)) - 131072;
      end else begin
        y = 3 * xs + 2 * m_x1 + m_x2 + int'($urandom_range(0, 4)) - 2;
      end
      strobe(y, 1);
      idle(int'($urandom_range(20, 26)));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
